// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch squash and a
// saturating count of inserted load-use bubbles.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [2:0]        id_funct3,
    input  logic              id_funct7b5,
    input  logic              flush,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [2:0]        ex_funct3,
    output logic              ex_funct7b5,
    output logic              stall,
    output logic [15:0]       bubble_count
);

    localparam int ALU_SRC   = 2;
    localparam int MEM_READ  = 5;
    localparam int MEM_WRITE = 6;

    logic              ex_valid_reg;
    logic [CTRL_W-1:0] ex_ctrl_reg;
    logic [XLEN-1:0]   ex_pc_reg;
    logic [XLEN-1:0]   ex_rs1_data_reg;
    logic [XLEN-1:0]   ex_rs2_data_reg;
    logic [XLEN-1:0]   ex_imm_reg;
    logic [4:0]        ex_rs1_reg;
    logic [4:0]        ex_rs2_reg;
    logic [4:0]        ex_rd_reg;
    logic [2:0]        ex_funct3_reg;
    logic              ex_funct7b5_reg;
    logic [15:0]       bubble_count_reg;

    logic rs1_used;
    logic rs2_used;
    logic hazard;
    logic load_en;

    // An all-zero control word is an undecoded opcode and reads nothing; rs2 is
    // read whenever the ALU takes a register operand, or by stores for data.
    assign rs1_used = id_valid && (id_ctrl != '0);
    assign rs2_used = rs1_used && (!id_ctrl[ALU_SRC] || id_ctrl[MEM_WRITE]);

    assign hazard = ex_valid_reg && ex_ctrl_reg[MEM_READ] && (ex_rd_reg != 5'd0)
                 && ((rs1_used && (ex_rd_reg == id_rs1)) ||
                     (rs2_used && (ex_rd_reg == id_rs2)));

    assign stall   = hazard && !flush;
    assign load_en = !reset && !flush && !hazard && id_valid;

    always_ff @(posedge clk) begin
        if (!load_en) begin
            ex_valid_reg    <= 1'b0;
            ex_ctrl_reg     <= '0;
            ex_pc_reg       <= '0;
            ex_rs1_data_reg <= '0;
            ex_rs2_data_reg <= '0;
            ex_imm_reg      <= '0;
            ex_rs1_reg      <= '0;
            ex_rs2_reg      <= '0;
            ex_rd_reg       <= '0;
            ex_funct3_reg   <= '0;
            ex_funct7b5_reg <= 1'b0;
        end else begin
            ex_valid_reg    <= 1'b1;
            ex_ctrl_reg     <= id_ctrl;
            ex_pc_reg       <= id_pc;
            ex_rs1_data_reg <= id_rs1_data;
            ex_rs2_data_reg <= id_rs2_data;
            ex_imm_reg      <= id_imm;
            ex_rs1_reg      <= id_rs1;
            ex_rs2_reg      <= id_rs2;
            ex_rd_reg       <= id_rd;
            ex_funct3_reg   <= id_funct3;
            ex_funct7b5_reg <= id_funct7b5;
        end
    end

    // Only bubbles that actually get inserted count; a flush overrides the hazard.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_count_reg <= '0;
        end else if (stall && (bubble_count_reg != 16'hFFFF)) begin
            bubble_count_reg <= bubble_count_reg + 16'd1;
        end
    end

    assign ex_valid     = ex_valid_reg;
    assign ex_ctrl      = ex_ctrl_reg;
    assign ex_pc        = ex_pc_reg;
    assign ex_rs1_data  = ex_rs1_data_reg;
    assign ex_rs2_data  = ex_rs2_data_reg;
    assign ex_imm       = ex_imm_reg;
    assign ex_rs1       = ex_rs1_reg;
    assign ex_rs2       = ex_rs2_reg;
    assign ex_rd        = ex_rd_reg;
    assign ex_funct3    = ex_funct3_reg;
    assign ex_funct7b5  = ex_funct7b5_reg;
    assign bubble_count = bubble_count_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic compared against an instruction-level model of the ID/EX slot.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [10:0] id_ctrl;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic        id_funct7b5;
    logic        flush;
    logic        ex_valid;
    logic [10:0] ex_ctrl;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic        stall;
    logic [15:0] bubble_count;

    int checks   = 0;
    int failures = 0;

    // Model of the instruction sitting in EX, kept as a plain record.
    typedef struct packed {
        logic        valid;
        logic [10:0] ctrl;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7;
    } slot_t;

    slot_t       m_ex;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .flush(flush),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .stall(stall), .bubble_count(bubble_count)
    );

    function automatic slot_t dut_slot();
        slot_t s;
        s = '{ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
              ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5};
        return s;
    endfunction

    // Does the ID instruction need the result of a load currently in EX?
    function automatic logic model_hazard();
        logic is_load_ex, reads1, reads2;
        is_load_ex = m_ex.valid && m_ex.ctrl[5] && (m_ex.rd != 5'd0);
        reads1 = id_valid && (id_ctrl != 11'd0);
        reads2 = reads1 && (!id_ctrl[2] || id_ctrl[6]);
        return is_load_ex && ((reads1 && m_ex.rd == id_rs1) || (reads2 && m_ex.rd == id_rs2));
    endfunction

    function automatic logic model_stall();
        return model_hazard() && !flush;
    endfunction

    task automatic drive(input logic v, input logic [10:0] c, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd, input logic fl);
        id_valid    = v;
        id_ctrl     = c;
        id_rs1      = r1;
        id_rs2      = r2;
        id_rd       = rd;
        flush       = fl;
        id_pc       = $urandom;
        id_rs1_data = $urandom;
        id_rs2_data = $urandom;
        id_imm      = $urandom;
        id_funct3   = 3'($urandom_range(0, 7));
        id_funct7b5 = 1'($urandom_range(0, 1));
        #1;
    endtask

    // Advance one clock edge, moving the model's EX slot the same way.
    task automatic tick();
        logic hz;
        hz = model_hazard();
        if (reset) begin
            m_ex  = '0;
            m_cnt = 16'd0;
        end else if (flush) begin
            m_ex = '0;
        end else if (hz) begin
            m_ex = '0;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else if (!id_valid) begin
            m_ex = '0;
        end else begin
            m_ex = '{1'b1, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
                     id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 11'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'b0);
        tick();
        drive(1'b1, 11'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'b0);
        tick();
        checks++; if (dut_slot() !== slot_t'(0)) begin failures++; $display("FAIL reset_slot got=%h exp=0", dut_slot()); end
        checks++; if (bubble_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%h exp=0000", bubble_count); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_pass_through();
        drive(1'b1, 11'h210, 5'd1, 5'd2, 5'd3, 1'b0);
        id_pc = 32'h100; id_rs1_data = 32'd5; id_rs2_data = 32'd7;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL pt_stall got=%b exp=0", stall); end
        tick();
        checks++; if (ex_ctrl !== 11'h210) begin failures++; $display("FAIL pt_ctrl got=%h exp=210", ex_ctrl); end
        checks++; if (ex_pc !== 32'h100 || ex_rs1_data !== 32'd5 || ex_rs2_data !== 32'd7)
            begin failures++; $display("FAIL pt_data got pc=%h a=%h b=%h exp pc=100 a=5 b=7", ex_pc, ex_rs1_data, ex_rs2_data); end
        checks++; if (ex_rd !== 5'd3 || ex_valid !== 1'b1)
            begin failures++; $display("FAIL pt_rd_valid got rd=%0d v=%b exp rd=3 v=1", ex_rd, ex_valid); end
        $display("test_pass_through done");
    endtask

    task automatic test_load_use();
        drive(1'b1, 11'h03c, 5'd1, 5'd0, 5'd5, 1'b0);
        tick();
        drive(1'b1, 11'h210, 5'd1, 5'd5, 5'd6, 1'b0);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 11'h000)
            begin failures++; $display("FAIL lu_bubble got v=%b ctrl=%h exp v=0 ctrl=000", ex_valid, ex_ctrl); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_stall_release got=%b exp=0", stall); end
        checks++; if (bubble_count !== 16'd1) begin failures++; $display("FAIL lu_count got=%0d exp=1", bubble_count); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_ctrl !== 11'h210 || ex_rd !== 5'd6)
            begin failures++; $display("FAIL lu_add_in_ex got v=%b ctrl=%h rd=%0d exp v=1 ctrl=210 rd=6", ex_valid, ex_ctrl, ex_rd); end
        $display("test_load_use done");
    endtask

    task automatic test_no_false_hazard();
        drive(1'b1, 11'h03c, 5'd1, 5'd0, 5'd5, 1'b0);
        tick();
        drive(1'b1, 11'h214, 5'd7, 5'd5, 5'd6, 1'b0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL nf_addi_stall got=%b exp=0", stall); end
        tick();
        drive(1'b1, 11'h03c, 5'd1, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b1, 11'h210, 5'd0, 5'd0, 5'd1, 1'b0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL nf_x0_stall got=%b exp=0", stall); end
        tick();
        checks++; if (bubble_count !== 16'd1) begin failures++; $display("FAIL nf_count got=%0d exp=1", bubble_count); end
        $display("test_no_false_hazard done");
    endtask

    task automatic test_store_rs2();
        drive(1'b1, 11'h03c, 5'd1, 5'd0, 5'd4, 1'b0);
        tick();
        drive(1'b1, 11'h045, 5'd2, 5'd4, 5'd0, 1'b0);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL st_stall got=%b exp=1", stall); end
        tick();
        checks++; if (bubble_count !== 16'd2) begin failures++; $display("FAIL st_count got=%0d exp=2", bubble_count); end
        tick();
        checks++; if (ex_ctrl !== 11'h045 || ex_valid !== 1'b1)
            begin failures++; $display("FAIL st_in_ex got ctrl=%h v=%b exp ctrl=045 v=1", ex_ctrl, ex_valid); end
        $display("test_store_rs2 done");
    endtask

    task automatic test_flush_priority();
        drive(1'b1, 11'h03c, 5'd1, 5'd0, 5'd5, 1'b0);
        tick();
        drive(1'b1, 11'h210, 5'd1, 5'd5, 5'd6, 1'b1);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL fl_stall got=%b exp=0", stall); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 11'h000)
            begin failures++; $display("FAIL fl_squash got v=%b ctrl=%h exp v=0 ctrl=000", ex_valid, ex_ctrl); end
        checks++; if (bubble_count !== 16'd2) begin failures++; $display("FAIL fl_count got=%0d exp=2", bubble_count); end
        flush = 1'b0;
        $display("test_flush_priority done");
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 11'h03c, 5'd1, 5'd0, 5'd5, 1'b0);
        tick();
        drive(1'b1, 11'h03c, 5'd5, 5'd0, 5'd6, 1'b0);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL b2b_stall got=%b exp=1", stall); end
        tick();
        checks++; if (stall !== 1'b0 || bubble_count !== 16'd3)
            begin failures++; $display("FAIL b2b_one_bubble got stall=%b cnt=%0d exp stall=0 cnt=3", stall, bubble_count); end
        tick();
        checks++; if (ex_ctrl !== 11'h03c || ex_rd !== 5'd6 || ex_valid !== 1'b1)
            begin failures++; $display("FAIL b2b_second_load got ctrl=%h rd=%0d v=%b exp ctrl=03c rd=6 v=1", ex_ctrl, ex_rd, ex_valid); end
        drive(1'b0, 11'h000, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 11'h03c, 5'd1, 5'd0, 5'd5, 1'b0);
        tick();
        drive(1'b1, 11'h210, 5'd1, 5'd5, 5'd6, 1'b0);
        reset = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rm_stall got=%b exp=1", stall); end
        tick();
        reset = 1'b0;
        #1;
        checks++; if (dut_slot() !== slot_t'(0) || bubble_count !== 16'd0)
            begin failures++; $display("FAIL rm_cleared got slot=%h cnt=%0d exp 0", dut_slot(), bubble_count); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rm_stall_after got=%b exp=0", stall); end
        tick();
        checks++; if (ex_ctrl !== 11'h210) begin failures++; $display("FAIL rm_add_in_ex got=%h exp=210", ex_ctrl); end
        $display("test_reset_mid_stall done");
    endtask

    task automatic test_saturation();
        dut.bubble_count_reg = 16'hFFFD;
        m_cnt = 16'hFFFD;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 11'h03c, 5'd1, 5'd0, 5'd5, 1'b0);
            tick();
            drive(1'b1, 11'h210, 5'd1, 5'd5, 5'd6, 1'b0);
            tick();
            checks++; if (bubble_count !== m_cnt)
                begin failures++; $display("FAIL sat_step%0d got=%h exp=%h", k, bubble_count, m_cnt); end
            tick();
        end
        checks++; if (bubble_count !== 16'hFFFF) begin failures++; $display("FAIL sat_final got=%h exp=ffff", bubble_count); end
        $display("test_saturation done");
    endtask

    task automatic test_random();
        logic [10:0] ctrl_tbl [7];
        logic        exp_stall;
        ctrl_tbl = '{11'h000, 11'h03c, 11'h210, 11'h214, 11'h045, 11'h180, 11'h03c};
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            drive(1'($urandom_range(0, 3) != 0), ctrl_tbl[$urandom_range(0, 6)],
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 9) == 0));
            exp_stall = model_stall();
            checks++; if (stall !== exp_stall)
                begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, stall, exp_stall); end
            tick();
            checks++; if (dut_slot() !== m_ex)
                begin failures++; $display("FAIL rnd_slot cyc=%0d got=%h exp=%h", i, dut_slot(), m_ex); end
            checks++; if (bubble_count !== m_cnt)
                begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, bubble_count, m_cnt); end
        end
        reset = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        m_ex  = '0;
        m_cnt = 16'd0;
        reset = 1'b1;
        flush = 1'b0;
        test_reset();
        test_pass_through();
        test_load_use();
        test_no_false_hazard();
        test_store_rs2();
        test_flush_priority();
        test_back_to_back();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
